// File: rtl/apple1_pkg.sv
// Shared register map and bit positions for the Apple-1 style PIA.
package apple1_pkg;

  localparam logic [15:0] PIA_BASE = 16'hD010;

  localparam logic [1:0] OFS_KBD   = 2'd0;
  localparam logic [1:0] OFS_KBDCR = 2'd1;
  localparam logic [1:0] OFS_DSP   = 2'd2;
  localparam logic [1:0] OFS_DSPCR = 2'd3;

  localparam int unsigned BIT_FLAG = 7;
  localparam int unsigned BIT_ERR  = 6;
  localparam int unsigned BIT_IE   = 0;

  localparam int unsigned CODE_W = 7;

  typedef enum logic {KBD_EMPTY, KBD_FULL} kbd_state_e;
  typedef enum logic {DSP_IDLE, DSP_BUSY} dsp_state_e;

endpackage

// File: rtl/apple1_pia_phi_edge.sv
// Samples the 6502 phi on the FPGA clock and flags its falling edge for one clk.
module phi_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic phi,
  output logic commit_c
);

  logic phi_q;
  logic phi_d;

  always_comb begin
    phi_d = phi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phi_q <= 1'b0;
    else        phi_q <= phi_d;
  end

  assign commit_c = phi_q & ~phi;

endmodule

// File: rtl/apple1_pia.sv
// Apple-1 style keyboard/display PIA on the 6502 bus: 4-register window,
// key latch with overrun, display valid/ready handshake and active-low irq.
module apple1_pia
  import apple1_pkg::*;
#(
  parameter logic [15:0] BASE = PIA_BASE
) (
  input  logic        clk,
  input  logic        res,
  input  logic        phi,
  input  logic [15:0] ab,
  input  logic        rw,
  input  logic [7:0]  dbo,
  output logic [7:0]  dbi,
  output logic        cs,
  output logic        irq,
  input  logic [6:0]  kbd_data,
  input  logic        kbd_strobe,
  output logic [6:0]  dsp_data,
  output logic        dsp_valid,
  input  logic        dsp_ready
);

  logic commit;
  logic [1:0] ofs;
  logic rd_commit, wr_commit;
  logic kbd_rd, kbdcr_rd, dspcr_rd, kbdcr_wr, dsp_wr, dspcr_wr;
  logic unused_dbo;

  kbd_state_e        kbd_state_q, kbd_state_d;
  dsp_state_e        dsp_state_q, dsp_state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] dsp_data_q, dsp_data_d;
  logic              ovr_q, ovr_d;
  logic              drop_q, drop_d;
  logic              kbd_ie_q, kbd_ie_d;
  logic              dsp_ie_q, dsp_ie_d;
  logic              irq_q, irq_d;
  logic              flag, busy;

  phi_edge u_phi_edge (
    .clk      (clk),
    .rst_n    (res),
    .phi      (phi),
    .commit_c (commit)
  );

  assign cs         = (ab[15:2] == BASE[15:2]);
  assign ofs        = ab[1:0];
  assign rd_commit  = commit & cs & rw;
  assign wr_commit  = commit & cs & ~rw;
  assign kbd_rd     = rd_commit & (ofs == OFS_KBD);
  assign kbdcr_rd   = rd_commit & (ofs == OFS_KBDCR);
  assign dspcr_rd   = rd_commit & (ofs == OFS_DSPCR);
  assign kbdcr_wr   = wr_commit & (ofs == OFS_KBDCR);
  assign dsp_wr     = wr_commit & (ofs == OFS_DSP);
  assign dspcr_wr   = wr_commit & (ofs == OFS_DSPCR);
  assign unused_dbo = dbo[7];

  assign flag = (kbd_state_q == KBD_FULL);
  assign busy = (dsp_state_q == DSP_BUSY);

  // Read mux: only drives data while the CPU is reading inside the window.
  always_comb begin
    dbi = 8'h00;
    if (cs && rw) begin
      unique case (ofs)
        OFS_KBD:   dbi = {flag, code_q};
        OFS_KBDCR: begin
          dbi[BIT_FLAG] = flag;
          dbi[BIT_ERR]  = ovr_q;
          dbi[BIT_IE]   = kbd_ie_q;
        end
        OFS_DSP:   dbi = {busy, dsp_data_q};
        OFS_DSPCR: begin
          dbi[BIT_FLAG] = ~busy;
          dbi[BIT_ERR]  = drop_q;
          dbi[BIT_IE]   = dsp_ie_q;
        end
        default:   dbi = 8'h00;
      endcase
    end
  end

  // Next-state for both FSMs; a set in the same clk as a clear wins.
  always_comb begin
    kbd_state_d = kbd_state_q;
    dsp_state_d = dsp_state_q;
    code_d      = code_q;
    dsp_data_d  = dsp_data_q;
    ovr_d       = ovr_q;
    drop_d      = drop_q;
    kbd_ie_d    = kbd_ie_q;
    dsp_ie_d    = dsp_ie_q;

    if (kbdcr_rd) ovr_d  = 1'b0;
    if (dspcr_rd) drop_d = 1'b0;
    if (kbdcr_wr) kbd_ie_d = dbo[0];
    if (dspcr_wr) dsp_ie_d = dbo[0];

    unique case (kbd_state_q)
      KBD_EMPTY: begin
        if (kbd_strobe) begin
          code_d      = kbd_data;
          kbd_state_d = KBD_FULL;
        end
      end
      KBD_FULL: begin
        if (kbd_strobe) begin
          code_d = kbd_data;
          if (!kbd_rd) ovr_d = 1'b1;
        end else if (kbd_rd) begin
          kbd_state_d = KBD_EMPTY;
        end
      end
      default: kbd_state_d = KBD_EMPTY;
    endcase

    unique case (dsp_state_q)
      DSP_IDLE: begin
        if (dsp_wr) begin
          dsp_data_d  = dbo[6:0];
          dsp_state_d = DSP_BUSY;
        end
      end
      DSP_BUSY: begin
        if (dsp_ready) begin
          if (dsp_wr) dsp_data_d  = dbo[6:0];
          else        dsp_state_d = DSP_IDLE;
        end else if (dsp_wr) begin
          drop_d = 1'b1;
        end
      end
      default: dsp_state_d = DSP_IDLE;
    endcase

    irq_d = ~((kbd_ie_q & flag) | (dsp_ie_q & ~busy));
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      kbd_state_q <= KBD_EMPTY;
      dsp_state_q <= DSP_IDLE;
      code_q      <= '0;
      dsp_data_q  <= '0;
      ovr_q       <= 1'b0;
      drop_q      <= 1'b0;
      kbd_ie_q    <= 1'b0;
      dsp_ie_q    <= 1'b0;
      irq_q       <= 1'b1;
    end else begin
      kbd_state_q <= kbd_state_d;
      dsp_state_q <= dsp_state_d;
      code_q      <= code_d;
      dsp_data_q  <= dsp_data_d;
      ovr_q       <= ovr_d;
      drop_q      <= drop_d;
      kbd_ie_q    <= kbd_ie_d;
      dsp_ie_q    <= dsp_ie_d;
      irq_q       <= irq_d;
    end
  end

  assign irq       = irq_q;
  assign dsp_data  = dsp_data_q;
  assign dsp_valid = busy;

endmodule

// File: tb/tb_apple1_pia.sv
// Directed vector bench for apple1_pia: register reads/writes, handshakes, irq, reset.
module tb_apple1_pia;

  logic        clk = 1'b0;
  logic        res;
  logic        phi;
  logic [15:0] ab;
  logic        rw;
  logic [7:0]  dbo;
  logic [7:0]  dbi;
  logic        cs;
  logic        irq;
  logic [6:0]  kbd_data;
  logic        kbd_strobe;
  logic [6:0]  dsp_data;
  logic        dsp_valid;
  logic        dsp_ready;

  int n_chk = 0;
  int n_pass = 0;

  apple1_pia #(.BASE(16'hD010)) dut (
    .clk        (clk),
    .res        (res),
    .phi        (phi),
    .ab         (ab),
    .rw         (rw),
    .dbo        (dbo),
    .dbi        (dbi),
    .cs         (cs),
    .irq        (irq),
    .kbd_data   (kbd_data),
    .kbd_strobe (kbd_strobe),
    .dsp_data   (dsp_data),
    .dsp_valid  (dsp_valid),
    .dsp_ready  (dsp_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        strobe;
    logic [6:0]  key;
    logic        ready;
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  wdata;
    logic        commit;
    logic [7:0]  exp_dbi;
    logic        exp_valid;
    logic        exp_irq;
    logic [6:0]  exp_dsp;
  } vec_t;

  localparam int NV = 21;
  vec_t tv[NV];

  function automatic vec_t mk(logic s, logic [6:0] k, logic r, logic [15:0] a,
                              logic w_rw, logic [7:0] wd, logic c, logic [7:0] ed,
                              logic ev, logic ei, logic [6:0] eds);
    vec_t v;
    v.strobe = s; v.key = k; v.ready = r; v.addr = a; v.rw = w_rw; v.wdata = wd;
    v.commit = c; v.exp_dbi = ed; v.exp_valid = ev; v.exp_irq = ei; v.exp_dsp = eds;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  task automatic addr_phase(input logic [15:0] a, input logic r, input logic [7:0] d);
    ab = a; rw = r; dbo = d; phi = 1'b1;
    tick();
    tick();
  endtask

  task automatic bus_end();
    ab = 16'h0000; rw = 1'b1; phi = 1'b0;
  endtask

  task automatic access(input logic [15:0] a, input logic r, input logic [7:0] d);
    addr_phase(a, r, d);
    phi = 1'b0;
    tick();
    bus_end();
  endtask

  initial begin
    // strobe key ready addr rw wdata commit exp_dbi valid irq dsp
    tv[0]  = mk(0, 7'h00, 0, 16'hD010, 1, 8'h00, 1, 8'h00, 0, 1, 7'h00);
    tv[1]  = mk(1, 7'h41, 0, 16'hD010, 1, 8'h00, 1, 8'hC1, 0, 1, 7'h00);
    tv[2]  = mk(0, 7'h00, 0, 16'hD010, 1, 8'h00, 1, 8'h41, 0, 1, 7'h00);
    tv[3]  = mk(1, 7'h41, 0, 16'hD013, 1, 8'h00, 1, 8'h80, 0, 1, 7'h00);
    tv[4]  = mk(1, 7'h42, 0, 16'hD011, 1, 8'h00, 1, 8'hC0, 0, 1, 7'h00);
    tv[5]  = mk(0, 7'h00, 0, 16'hD011, 1, 8'h00, 1, 8'h80, 0, 1, 7'h00);
    tv[6]  = mk(0, 7'h00, 0, 16'hD010, 1, 8'h00, 1, 8'hC2, 0, 1, 7'h00);
    tv[7]  = mk(0, 7'h00, 0, 16'hD011, 1, 8'h00, 1, 8'h00, 0, 1, 7'h00);
    tv[8]  = mk(0, 7'h00, 0, 16'hD012, 0, 8'h0D, 1, 8'h00, 1, 1, 7'h0D);
    tv[9]  = mk(0, 7'h00, 0, 16'hD012, 1, 8'h00, 1, 8'h8D, 1, 1, 7'h0D);
    tv[10] = mk(0, 7'h00, 0, 16'hD012, 0, 8'h35, 1, 8'h00, 1, 1, 7'h0D);
    tv[11] = mk(0, 7'h00, 0, 16'hD013, 1, 8'h00, 0, 8'h40, 1, 1, 7'h0D);
    tv[12] = mk(0, 7'h00, 0, 16'hD012, 1, 8'h00, 1, 8'h8D, 1, 1, 7'h0D);
    tv[13] = mk(0, 7'h00, 1, 16'hD013, 1, 8'h00, 1, 8'hC0, 0, 1, 7'h0D);
    tv[14] = mk(0, 7'h00, 0, 16'hD013, 1, 8'h00, 1, 8'h80, 0, 1, 7'h0D);
    tv[15] = mk(0, 7'h00, 0, 16'hD011, 0, 8'h01, 1, 8'h00, 0, 1, 7'h0D);
    tv[16] = mk(0, 7'h00, 0, 16'hD013, 0, 8'h01, 1, 8'h00, 0, 0, 7'h0D);
    tv[17] = mk(0, 7'h00, 0, 16'hD013, 1, 8'h00, 0, 8'h81, 0, 0, 7'h0D);
    tv[18] = mk(0, 7'h00, 0, 16'hD012, 0, 8'h41, 1, 8'h00, 1, 1, 7'h41);
    tv[19] = mk(1, 7'h55, 0, 16'hD010, 1, 8'h00, 0, 8'hD5, 1, 0, 7'h41);
    tv[20] = mk(0, 7'h00, 0, 16'hD011, 1, 8'h00, 0, 8'h81, 1, 0, 7'h41);

    res = 1'b0; phi = 1'b0; ab = 16'h0000; rw = 1'b1; dbo = 8'h00;
    kbd_data = 7'h00; kbd_strobe = 1'b0; dsp_ready = 1'b0;

    // Reset held with random bus activity outside the window
    for (int i = 0; i < 8; i++) begin
      ab = 16'($urandom_range(0, 16'hCFFF));
      rw = 1'($urandom);
      dbo = 8'($urandom);
      phi = 1'($urandom);
      kbd_data = 7'($urandom);
      kbd_strobe = 1'($urandom);
      dsp_ready = 1'($urandom);
      tick();
    end
    check("rst dsp_valid", {7'b0, dsp_valid}, 8'h00);
    check("rst irq", {7'b0, irq}, 8'h01);
    check("rst dbi", dbi, 8'h00);
    kbd_strobe = 1'b0; dsp_ready = 1'b0; phi = 1'b0;
    ab = 16'hD010; rw = 1'b1;
    #1;
    check("rst kbd read", dbi, 8'h00);
    bus_end();
    tick();
    res = 1'b1;
    tick();
    tick();

    for (int i = 0; i < NV; i++) begin
      if (tv[i].strobe) begin
        kbd_data = tv[i].key; kbd_strobe = 1'b1;
        tick();
        kbd_strobe = 1'b0;
      end
      if (tv[i].ready) begin
        dsp_ready = 1'b1;
        tick();
        dsp_ready = 1'b0;
      end
      addr_phase(tv[i].addr, tv[i].rw, tv[i].wdata);
      check($sformatf("vec%0d dbi", i), dbi, tv[i].exp_dbi);
      if (tv[i].commit) begin
        phi = 1'b0;
        tick();
      end
      bus_end();
      tick();
      check($sformatf("vec%0d dsp_valid", i), {7'b0, dsp_valid}, {7'b0, tv[i].exp_valid});
      check($sformatf("vec%0d irq", i), {7'b0, irq}, {7'b0, tv[i].exp_irq});
      check($sformatf("vec%0d dsp_data", i), {1'b0, dsp_data}, {1'b0, tv[i].exp_dsp});
    end

    // Reset in the middle of a pending display character acts without a clock
    #2;
    res = 1'b0;
    #1;
    check("midrst dsp_valid", {7'b0, dsp_valid}, 8'h00);
    check("midrst irq", {7'b0, irq}, 8'h01);
    check("midrst dsp_data", {1'b0, dsp_data}, 8'h00);
    tick();
    res = 1'b1;
    tick();

    // irq latency: unchanged on the commit edge, asserted one clk later
    addr_phase(16'hD013, 1'b0, 8'h01);
    phi = 1'b0;
    tick();
    bus_end();
    check("irq at commit", {7'b0, irq}, 8'h01);
    tick();
    check("irq one clk later", {7'b0, irq}, 8'h00);

    // Key strobe in the same clk as the KBD read commit
    kbd_data = 7'h11; kbd_strobe = 1'b1;
    tick();
    kbd_strobe = 1'b0;
    addr_phase(16'hD010, 1'b1, 8'h00);
    check("sim kbd pre", dbi, 8'h91);
    phi = 1'b0; kbd_data = 7'h22; kbd_strobe = 1'b1;
    tick();
    kbd_strobe = 1'b0;
    bus_end();
    tick();
    addr_phase(16'hD010, 1'b1, 8'h00);
    check("sim kbd code", dbi, 8'hA2);
    bus_end();
    tick();
    access(16'hD011, 1'b1, 8'h00);
    addr_phase(16'hD011, 1'b1, 8'h00);
    check("sim kbd no ovr", dbi, 8'h80);
    bus_end();
    tick();

    // Display write in the same clk as dsp_ready
    access(16'hD012, 1'b0, 8'h0D);
    tick();
    check("sim dsp busy", {7'b0, dsp_valid}, 8'h01);
    addr_phase(16'hD012, 1'b0, 8'h35);
    phi = 1'b0; dsp_ready = 1'b1;
    tick();
    dsp_ready = 1'b0;
    bus_end();
    tick();
    check("sim dsp valid", {7'b0, dsp_valid}, 8'h01);
    check("sim dsp data", {1'b0, dsp_data}, 8'h35);
    addr_phase(16'hD013, 1'b1, 8'h00);
    check("sim dsp no drop", dbi, 8'h01);
    bus_end();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/apple1_pia.md
Name: apple1_pia

Overview:
- Memory-mapped keyboard/display peripheral that sits directly downstream of chip_6502 on its bus.
- Consumes the CPU address bus, rw and write data, and returns read data on the CPU data-in bus (dbi).
- Provides an Apple-1-style 4-register interface: key input latch, display output with valid/ready handshake, and active-low interrupt request.
- All logic runs on the single FPGA clock; phi is sampled as a data signal to find bus commit points.

Parameters:
- BASE, 16'hD010, base address of the 4-register window; bits [1:0] must be 0.

Ports:
- clk  in  1  FPGA clock; the only clock.
- res  in  1  reset; asynchronous, active-low.
- phi  in  1  6502 clock, sampled on clk.
- ab  in  16  CPU address bus.
- rw  in  1  CPU read(1)/write(0).
- dbo  in  8  CPU write data.
- dbi  out  8  read data to CPU.
- cs  out  1  high when ab is inside the window; used by the upstream data mux.
- irq  out  1  interrupt to CPU, active-low, registered.
- kbd_data  in  7  key code.
- kbd_strobe  in  1  one-clk pulse: kbd_data valid.
- dsp_data  out  7  character to display.
- dsp_valid  out  1  dsp_data pending.
- dsp_ready  in  1  display accepts the character.

Behaviour:
- Reset (res low, async): all state clears. kbd flag=0, key code=0, overrun=0, kbd_ie=0, dsp busy=0, dsp_data=0, drop=0, dsp_ie=0, irq=1, phi_q=0. dsp_valid=0. dbi is 0 because no read is decoded.
- Address decode (combinational):
  - cs = (ab[15:2]==BASE[15:2]).
  - Register offset = ab[1:0]: 0 KBD, 1 KBDCR, 2 DSP, 3 DSPCR.
- Commit edge: phi_q registers phi each clk. commit = phi_q & ~phi, the phi falling edge. It lasts exactly one clk.
- Read data (combinational): dbi = 8'h00 unless cs & rw. When cs & rw:
  - KBD = {flag, code}.
  - KBDCR = {flag, overrun, 5'b0, kbd_ie}.
  - DSP = {busy, dsp_data}.
  - DSPCR = {~busy, drop, 5'b0, dsp_ie}.
- Read side effects (on commit & cs & rw only):
  - KBD read clears flag.
  - KBDCR read clears overrun.
  - DSPCR read clears drop.
- Writes (on commit & cs & ~rw):
  - KBD: ignored.
  - KBDCR: kbd_ie=dbo[0].
  - DSP: see display FSM.
  - DSPCR: dsp_ie=dbo[0].
- Keyboard FSM, states EMPTY (flag=0) and FULL (flag=1):
  - EMPTY + strobe: latch code, go FULL.
  - FULL + strobe: overwrite code (latest key wins), set overrun.
  - FULL + KBD read commit: go EMPTY.
  - Strobe and KBD-read commit in the same clk: new code loaded, stay FULL, overrun not set.
- Display FSM, states IDLE (busy=0) and BUSY (busy=1). dsp_valid = busy.
  - IDLE + DSP write: dsp_data=dbo[6:0], go BUSY.
  - BUSY + dsp_ready: go IDLE. dsp_data holds its value.
  - BUSY + DSP write without dsp_ready: write dropped, drop=1, dsp_data unchanged.
  - BUSY + dsp_ready + DSP write in the same clk: old character consumed, new data loaded, stay BUSY, no drop.
  - dsp_data must not change while dsp_valid=1 && !dsp_ready.
- irq (registered, 1 clk latency): irq <= ~((kbd_ie & flag) | (dsp_ie & ~busy)).
- A mid-operation reset abandons a pending display character. dsp_valid drops asynchronously.

Decomposition:
- Shared package apple1_pkg holds:
  - register offsets OFS_KBD=0, OFS_KBDCR=1, OFS_DSP=2, OFS_DSPCR=3;
  - bit positions BIT_FLAG=7, BIT_ERR=6, BIT_IE=0;
  - default PIA_BASE=16'hD010.
- One natural sub-module, phi_edge: registers phi on clk, asynchronous active-low reset, outputs a one-clk commit pulse on the phi falling edge. It is reusable by the RAM/ROM bus stages.

Test Plan:
- Reset: hold res=0 with random bus inputs -> dsp_valid=0, irq=1, dbi=8'h00. Then read KBD at 16'hD010 -> dbi=8'h00.
- Key path: pulse kbd_strobe with kbd_data=7'h41, read D010 -> dbi=8'hC1. After the phi falling edge, re-read -> 8'h41.
- Overrun: two strobes 7'h41 then 7'h42 with no read -> KBD=8'hC2, KBDCR=8'hC0. Read KBDCR, then KBDCR=8'h80.
- Display handshake: write 8'h0D to D012 with dsp_ready=0 -> dsp_valid=1, dsp_data=7'h0D, DSP reads 8'h8D. Write 8'h35 -> dropped, DSPCR=8'h40. Raise dsp_ready 1 clk -> dsp_valid=0, DSPCR=8'hC0.
- Simultaneous events: kbd_strobe in the same clk as the KBD-read commit -> flag stays 1, new code loaded, overrun=0. DSP write in the same clk as dsp_ready -> new data loaded, stays BUSY, drop=0.
- IRQ: write 8'h01 to D011 and D013 while idle -> irq=0 one clk after the DSPCR commit. Write D012 -> irq=1 until ready. Strobe a key -> irq=0. Assert res mid-BUSY -> dsp_valid=0, irq=1 immediately.
